// File: rtl/lsu_split_if.sv
// Request/response handshake bundle between the MEM stage and lsu_split.
// master = core side, slave = load/store unit.
interface lsu_split_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_wren;
    logic [2:0]  i_funct3;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;

    modport master (
        output i_req_valid, i_addr, i_wdata, i_wren, i_funct3, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
    );

    modport slave (
        input  i_req_valid, i_addr, i_wdata, i_wren, i_funct3, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err
    );
endinterface

// File: rtl/lsu_split.sv
// Handshaked RV32 load/store unit: single-port word RAM plus MMIO channels.
// Word-crossing RAM accesses run as two sequential word beats.
module lsu_split #(
    parameter int          DMEM_WORDS = 16384,
    parameter int          NUM_OUT    = 4,
    parameter int          NUM_IN     = 2,
    parameter logic [31:0] OUT_BASE   = 32'h1000_0000,
    parameter logic [31:0] IN_BASE    = 32'h1001_0000,
    parameter logic [31:0] OUT_RESET  = 32'h0
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    lsu_split_if.slave              bus,
    output logic [32*NUM_OUT-1:0]   o_io_out,
    input  logic [32*NUM_IN-1:0]    i_io_in
);

    localparam int AW  = $clog2(DMEM_WORDS);
    localparam int OCW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int ICW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [19:0] OUT_PG = OUT_BASE[31:12];
    localparam logic [19:0] IN_PG  = IN_BASE[31:12];

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;
    typedef enum logic [1:0] {K_RAM, K_OUT, K_IN} kind_t;

    state_t          state_q, state_d;
    kind_t           kind_q, kind_d, req_kind;
    logic [AW-1:0]   idx_q, idx_d;
    logic [1:0]      off_q, off_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            wren_q, wren_d;
    logic [2:0]      f3_q, f3_d;
    logic            err_q, err_d;
    logic            split_q, split_d;
    logic [19:0]     chan_q, chan_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     io_rd_q, io_rd_d;
    logic [31:0]     out_q [NUM_OUT];
    logic [31:0]     out_d [NUM_OUT];

    logic [31:0]     mem [DMEM_WORDS];
    logic [31:0]     ram_rdata_q;

    // Request decode, evaluated on the bus while IDLE
    logic [1:0]      req_off;
    logic [2:0]      req_size;
    logic            req_over;
    logic            req_mis_io;
    logic            req_f3_bad;
    logic            hit_ram, hit_out, hit_in;
    logic [19:0]     out_idx, in_idx;
    logic [31:0]     next_word;
    logic            split_oob;
    logic            req_err;
    logic            req_split;

    always_comb begin
        req_off  = bus.i_addr[1:0];
        req_size = 3'd4;
        unique case (bus.i_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        req_over   = ({1'b0, req_off} + req_size) > 3'd4;
        req_mis_io = req_over
                   | ((req_size == 3'd2) & req_off[0])
                   | ((req_size == 3'd4) & (req_off != 2'd0));
        req_f3_bad = (bus.i_funct3 == 3'b011)
                   | (bus.i_funct3 == 3'b110)
                   | (bus.i_funct3 == 3'b111)
                   | (bus.i_wren & bus.i_funct3[2]);
        hit_ram   = {2'b00, bus.i_addr[31:2]} < 32'(DMEM_WORDS);
        out_idx   = bus.i_addr[31:12] - OUT_PG;
        in_idx    = bus.i_addr[31:12] - IN_PG;
        hit_out   = !hit_ram && (out_idx < 20'(NUM_OUT));
        hit_in    = !hit_ram && !hit_out && (in_idx < 20'(NUM_IN));
        next_word = {2'b00, bus.i_addr[31:2]} + 32'd1;
        split_oob = next_word >= 32'(DMEM_WORDS);
        req_split = hit_ram & req_over;
        req_kind  = hit_out ? K_OUT : (hit_in ? K_IN : K_RAM);
        req_err   = req_f3_bad
                  | !(hit_ram | hit_out | hit_in)
                  | ((hit_out | hit_in) & req_mis_io)
                  | (req_split & split_oob)
                  | (hit_in & bus.i_wren);
    end

    // Store lane steering from the latched request
    logic [7:0]      szmask;
    logic [7:0]      mask8;
    logic [63:0]     wide;
    logic [OCW-1:0]  oc;
    logic [ICW-1:0]  ic;

    always_comb begin
        unique case (f3_q[1:0])
            2'b00:   szmask = 8'b0000_0001;
            2'b01:   szmask = 8'b0000_0011;
            default: szmask = 8'b0000_1111;
        endcase
        mask8 = szmask << off_q;
        wide  = {32'b0, wdata_q} << {off_q, 3'b000};
        oc    = chan_q[OCW-1:0];
        ic    = chan_q[ICW-1:0];
    end

    // RAM port control
    logic            ram_en, ram_we;
    logic [3:0]      ram_be;
    logic [31:0]     ram_wd;
    logic [AW-1:0]   ram_idx;

    always_comb begin
        ram_en  = (state_q == ACC1 || state_q == ACC2) && kind_q == K_RAM;
        ram_we  = ram_en & wren_q;
        ram_be  = (state_q == ACC2) ? mask8[7:4] : mask8[3:0];
        ram_wd  = (state_q == ACC2) ? wide[63:32] : wide[31:0];
        ram_idx = (state_q == ACC2) ? idx_q + AW'(1) : idx_q;
    end

    always_ff @(posedge i_clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we && ram_be[b]) begin
                    mem[ram_idx][8*b +: 8] <= ram_wd[8*b +: 8];
                end
            end
            ram_rdata_q <= mem[ram_idx];
        end
    end

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        idx_d   = idx_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        wren_d  = wren_q;
        f3_d    = f3_q;
        err_d   = err_q;
        split_d = split_q;
        chan_d  = chan_q;
        lo_d    = lo_q;
        io_rd_d = io_rd_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    idx_d   = bus.i_addr[AW+1:2];
                    off_d   = req_off;
                    wdata_d = bus.i_wdata;
                    wren_d  = bus.i_wren;
                    f3_d    = bus.i_funct3;
                    kind_d  = req_kind;
                    chan_d  = hit_out ? out_idx : in_idx;
                    split_d = req_split;
                    err_d   = req_err;
                    state_d = req_err ? RESP : ACC1;
                end
            end
            ACC1: begin
                if (kind_q == K_OUT) begin
                    io_rd_d = out_q[oc];
                    if (wren_q) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mask8[b]) out_d[oc][8*b +: 8] = wide[8*b +: 8];
                        end
                    end
                end else if (kind_q == K_IN) begin
                    io_rd_d = i_io_in[32*ic +: 32];
                end
                state_d = split_q ? ACC2 : RESP;
            end
            ACC2: begin
                lo_d    = ram_rdata_q;
                state_d = RESP;
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            kind_q  <= K_RAM;
            idx_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            f3_q    <= '0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            chan_q  <= '0;
            lo_q    <= '0;
            io_rd_q <= '0;
            for (int k = 0; k < NUM_OUT; k++) out_q[k] <= OUT_RESET;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            f3_q    <= f3_d;
            err_q   <= err_d;
            split_q <= split_d;
            chan_q  <= chan_d;
            lo_q    <= lo_d;
            io_rd_q <= io_rd_d;
            out_q   <= out_d;
        end
    end

    // Load assembly: split beats form a 64-bit window, then shift by offset
    logic [63:0]     asm_w;
    logic [63:0]     asm_sh;
    logic [31:0]     ld_word;
    logic [31:0]     ld_ext;

    always_comb begin
        if (split_q) begin
            asm_w = {ram_rdata_q, lo_q};
        end else begin
            asm_w = {32'b0, (kind_q == K_RAM) ? ram_rdata_q : io_rd_q};
        end
        asm_sh  = asm_w >> {off_q, 3'b000};
        ld_word = asm_sh[31:0];
        unique case (f3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_ext = {24'b0, ld_word[7:0]};
            3'b101:  ld_ext = {16'b0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    assign bus.o_req_ready = (state_q == IDLE);
    assign bus.o_rsp_valid = (state_q == RESP);
    assign bus.o_rsp_err   = (state_q == RESP) & err_q;
    assign bus.o_rsp_data  = (state_q == RESP && !err_q && !wren_q) ? ld_ext : 32'b0;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        assign o_io_out[32*k +: 32] = out_q[k];
    end

    logic unused_ok;
    assign unused_ok = ^{asm_sh[63:32]};

endmodule

// File: tb/tb_lsu_split.sv
// Directed self-checking bench for lsu_split: RAM, split, MMIO, errors,
// response backpressure and mid-access reset.
module tb_lsu_split;

    localparam int DW = 16384;

    logic          clk;
    logic          rst_n;
    logic [127:0]  io_out;
    logic [63:0]   io_in;
    int            nchk;
    int            nerr;

    lsu_split_if bus ();

    lsu_split #(
        .DMEM_WORDS (DW),
        .NUM_OUT    (4),
        .NUM_IN     (2),
        .OUT_BASE   (32'h1000_0000),
        .IN_BASE    (32'h1001_0000),
        .OUT_RESET  (32'h0)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .bus      (bus),
        .o_io_out (io_out),
        .i_io_in  (io_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at #1 after an edge with the unit idle; returns after consumption
    task automatic xfer(input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        bus.i_req_valid = 1'b1;
        bus.i_wren      = wr;
        bus.i_funct3    = f3;
        bus.i_addr      = a;
        bus.i_wdata     = wd;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        lat = 1;
        while (!bus.o_rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = bus.o_rsp_data;
        er = bus.o_rsp_err;
        if (!bus.o_rsp_valid) chk("rsp_timeout", 32'(bus.o_rsp_valid), 32'd1);
        if (bus.i_rsp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] held;

    initial begin
        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        io_in = {32'hCAFE_F00D, 32'h1234_5678};
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        bus.i_addr = '0;
        bus.i_wdata = '0;
        bus.i_wren = 1'b0;
        bus.i_funct3 = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.o_req_ready), 32'd1);
        chk("rst_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("rst_data", bus.o_rsp_data, 32'd0);
        chk("rst_out0", io_out[31:0], 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, rd, er, lat);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_data0", rd, 32'd0);
        xfer(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_data", rd, 32'hDEAD_BEEF);
        chk("lw_err", 32'(er), 32'd0);
        xfer(1'b0, 3'b000, 32'h103, 32'h0, rd, er, lat);
        chk("lb_data", rd, 32'hFFFF_FFDE);
        xfer(1'b0, 3'b100, 32'h103, 32'h0, rd, er, lat);
        chk("lbu_data", rd, 32'h0000_00DE);

        xfer(1'b1, 3'b010, 32'h200, 32'h0, rd, er, lat);
        xfer(1'b1, 3'b010, 32'h204, 32'h0, rd, er, lat);
        xfer(1'b1, 3'b010, 32'h300, 32'h0, rd, er, lat);
        xfer(1'b1, 3'b010, 32'h202, 32'h1122_3344, rd, er, lat);
        chk("split_sw_lat", 32'(lat), 32'd3);
        xfer(1'b0, 3'b010, 32'h200, 32'h0, rd, er, lat);
        chk("lw_200", rd, 32'h3344_0000);
        xfer(1'b0, 3'b010, 32'h204, 32'h0, rd, er, lat);
        chk("lw_204", rd, 32'h0000_1122);
        xfer(1'b0, 3'b010, 32'h202, 32'h0, rd, er, lat);
        chk("split_lw", rd, 32'h1122_3344);
        chk("split_lw_lat", 32'(lat), 32'd3);
        xfer(1'b0, 3'b001, 32'h203, 32'h0, rd, er, lat);
        chk("split_lh", rd, 32'h0000_2233);
        xfer(1'b0, 3'b000, 32'h205, 32'h0, rd, er, lat);
        chk("lb_205", rd, 32'h0000_0011);

        xfer(1'b1, 3'b000, 32'h1000_1002, 32'h0000_00A5, rd, er, lat);
        chk("io_sb_lat", 32'(lat), 32'd2);
        chk("io_ch1", io_out[63:32], 32'h00A5_0000);
        chk("io_ch0", io_out[31:0], 32'h0);
        chk("io_ch2", io_out[95:64], 32'h0);
        chk("io_ch3", io_out[127:96], 32'h0);
        xfer(1'b0, 3'b010, 32'h1000_1000, 32'h0, rd, er, lat);
        chk("io_lw", rd, 32'h00A5_0000);
        xfer(1'b0, 3'b100, 32'h1000_1002, 32'h0, rd, er, lat);
        chk("io_lbu", rd, 32'h0000_00A5);
        xfer(1'b0, 3'b010, 32'h1001_1000, 32'h0, rd, er, lat);
        chk("in_lw", rd, 32'hCAFE_F00D);
        xfer(1'b0, 3'b001, 32'h1001_0002, 32'h0, rd, er, lat);
        chk("in_lh", rd, 32'h0000_1234);

        xfer(1'b0, 3'b010, 32'h2000_0000, 32'h0, rd, er, lat);
        chk("unmap_err", 32'(er), 32'd1);
        chk("unmap_lat", 32'(lat), 32'd1);
        chk("unmap_data", rd, 32'd0);
        xfer(1'b1, 3'b010, 32'h1000_0001, 32'hFFFF_FFFF, rd, er, lat);
        chk("mis_io_err", 32'(er), 32'd1);
        chk("mis_io_lat", 32'(lat), 32'd1);
        chk("mis_io_ch0", io_out[31:0], 32'h0);
        xfer(1'b0, 3'b010, 32'(4*DW-2), 32'h0, rd, er, lat);
        chk("oob_err", 32'(er), 32'd1);
        chk("oob_lat", 32'(lat), 32'd1);
        xfer(1'b0, 3'b011, 32'h100, 32'h0, rd, er, lat);
        chk("f3_err", 32'(er), 32'd1);
        chk("f3_data", rd, 32'd0);
        xfer(1'b1, 3'b100, 32'h100, 32'h0, rd, er, lat);
        chk("sbu_err", 32'(er), 32'd1);
        xfer(1'b1, 3'b010, 32'h1001_0000, 32'h0, rd, er, lat);
        chk("st_in_err", 32'(er), 32'd1);
        xfer(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
        chk("no_side_eff", rd, 32'hDEAD_BEEF);

        bus.i_rsp_ready = 1'b0;
        xfer(1'b0, 3'b010, 32'h202, 32'h0, rd, er, lat);
        held = rd;
        chk("hold_first", held, 32'h1122_3344);
        bus.i_req_valid = 1'b1;
        bus.i_wren      = 1'b1;
        bus.i_funct3    = 3'b010;
        bus.i_addr      = 32'h300;
        bus.i_wdata     = 32'h5555_AAAA;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_data", bus.o_rsp_data, held);
            chk("hold_valid", 32'(bus.o_rsp_valid), 32'd1);
            chk("hold_ready", 32'(bus.o_req_ready), 32'd0);
        end
        bus.i_req_valid = 1'b0;
        bus.i_rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", 32'(bus.o_req_ready), 32'd1);
        chk("rel_valid", 32'(bus.o_rsp_valid), 32'd0);
        xfer(1'b0, 3'b010, 32'h300, 32'h0, rd, er, lat);
        chk("ignored_req", rd, 32'h0);

        bus.i_req_valid = 1'b1;
        bus.i_wren      = 1'b0;
        bus.i_funct3    = 3'b010;
        bus.i_addr      = 32'h100;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("arst_data", bus.o_rsp_data, 32'd0);
        chk("arst_ch1", io_out[63:32], 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(bus.o_req_ready), 32'd1);
        xfer(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
        chk("post_rst_lw", rd, 32'hDEAD_BEEF);
        chk("post_rst_lat", 32'(lat), 32'd2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
